// File: rtl/mdio_config_sequencer.sv
// Table-driven PHY configuration engine: walks a packed list of WRITE / READ_VERIFY /
// POLL / END entries and issues them as AXI-lite transactions to a multi-PHY MDIO master.
module mdio_config_sequencer #(
  parameter int NUM_ENTRIES    = 4,
  parameter int POLL_LIMIT     = 16,
  parameter int POLL_INTERVAL  = 1024,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter bit AUTO_START     = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [44*NUM_ENTRIES-1:0] cfg_table,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [4:0]                error_index,
  output logic [1:0]                error_code,
  output logic [15:0]               last_rdata,
  output logic [9:0]                awaddr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [15:0]               wdata,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [9:0]                araddr,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [15:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [3:0]                fsm_state
);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid && ready; a raised valid (with its payload) is held until that edge.

  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam int WW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_ENTRIES - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(POLL_INTERVAL - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP,
    S_CHECK, S_POLL_WAIT, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic          auto_pend;
  logic [IW-1:0] idx;
  logic [PW-1:0] poll_cnt;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] tcnt;
  logic          e_poll;
  logic [15:0]   e_data;
  logic [15:0]   e_mask;
  logic [43:0]   entry_tab [NUM_ENTRIES];
  logic [43:0]   cur;
  logic          match;
  logic          timeout;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    assign entry_tab[g] = cfg_table[44*g +: 44];
  end

  assign cur       = entry_tab[idx];
  assign match     = ((last_rdata ^ e_data) & e_mask) == 16'h0000;
  assign timeout   = (tcnt == TO_LAST);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      auto_pend   <= AUTO_START;
      idx         <= '0;
      poll_cnt    <= '0;
      wait_cnt    <= '0;
      tcnt        <= '0;
      e_poll      <= 1'b0;
      e_data      <= '0;
      e_mask      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      error_index <= '0;
      error_code  <= '0;
      last_rdata  <= '0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
    end else begin
      // Phase timer runs only in the four handshake states; it restarts on every entry.
      tcnt <= (state == S_WR_REQ || state == S_WR_RESP || state == S_RD_REQ ||
               state == S_RD_RESP) ? tcnt + TW'(1) : '0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start || auto_pend) begin
            auto_pend   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            error_code  <= '0;
            error_index <= '0;
            idx         <= '0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          e_poll   <= (cur[43:42] == OP_POLL);
          e_data   <= cur[31:16];
          e_mask   <= cur[15:0];
          poll_cnt <= '0;
          case (cur[43:42])
            OP_WRITE: begin
              awaddr  <= cur[41:32];
              wdata   <= cur[31:16];
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WR_REQ;
            end
            OP_END: begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
            default: begin
              araddr  <= cur[41:32];
              arvalid <= 1'b1;
              state   <= S_RD_REQ;
            end
          endcase
        end
        S_WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            tcnt   <= '0;
            state  <= S_WR_RESP;
          end else if (timeout) begin
            awvalid <= 1'b0; wvalid <= 1'b0;
            state <= S_ERROR; busy <= 1'b0; error <= 1'b1; error_index <= 5'(idx); error_code <= 2'b11;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != 2'b00) begin
              state <= S_ERROR; busy <= 1'b0; error <= 1'b1; error_index <= 5'(idx); error_code <= 2'b01;
            end else begin
              state <= S_NEXT;
            end
          end else if (timeout) begin
            bready <= 1'b0;
            state <= S_ERROR; busy <= 1'b0; error <= 1'b1; error_index <= 5'(idx); error_code <= 2'b11;
          end
        end
        S_RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            tcnt    <= '0;
            state   <= S_RD_RESP;
          end else if (timeout) begin
            arvalid <= 1'b0;
            state <= S_ERROR; busy <= 1'b0; error <= 1'b1; error_index <= 5'(idx); error_code <= 2'b11;
          end
        end
        S_RD_RESP: begin
          if (rvalid) begin
            last_rdata <= rdata;
            rready     <= 1'b0;
            if (rresp != 2'b00) begin
              state <= S_ERROR; busy <= 1'b0; error <= 1'b1; error_index <= 5'(idx); error_code <= 2'b01;
            end else begin
              state <= S_CHECK;
            end
          end else if (timeout) begin
            rready <= 1'b0;
            state <= S_ERROR; busy <= 1'b0; error <= 1'b1; error_index <= 5'(idx); error_code <= 2'b11;
          end
        end
        S_CHECK: begin
          if (match) begin
            state <= S_NEXT;
          end else if (!e_poll || poll_cnt == POLL_LAST) begin
            state <= S_ERROR; busy <= 1'b0; error <= 1'b1; error_index <= 5'(idx); error_code <= 2'b10;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
            wait_cnt <= '0;
            state    <= S_POLL_WAIT;
          end
        end
        S_POLL_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            arvalid <= 1'b1;
            state   <= S_RD_REQ;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_config_sequencer.sv
// Directed bench for mdio_config_sequencer: a scripted AXI-lite slave, a table-level
// model of the expected transactions/outcome, and a per-cycle compare process.
module tb_mdio_config_sequencer;

  localparam int NE = 3;
  localparam int PL = 4;
  localparam int PI = 8;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [44*NE-1:0] cfg_table = '0;
  logic          busy, done, error;
  logic [4:0]    error_index;
  logic [1:0]    error_code;
  logic [15:0]   last_rdata;
  logic [9:0]    awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [15:0]   wdata;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [15:0]   rdata = 16'h0;
  logic [3:0]    fsm_state;

  mdio_config_sequencer #(
    .NUM_ENTRIES(NE), .POLL_LIMIT(PL), .POLL_INTERVAL(PI),
    .TIMEOUT_CYCLES(TO), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg_table(cfg_table),
    .busy(busy), .done(done), .error(error), .error_index(error_index),
    .error_code(error_code), .last_rdata(last_rdata),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  int total = 0;
  int bad = 0;
  logic [9:0]  exp_aw_q[$];
  logic [15:0] exp_w_q[$];
  logic [9:0]  exp_ar_q[$];
  int          ar_times[$];
  int          cyc = 0;
  int          stag_cnt = 0;
  int          aw_hs_cnt = 0;
  logic        exp_done, exp_err;
  logic [4:0]  exp_idx;
  logic [1:0]  exp_code;
  logic [15:0] m_last = 16'h0;

  // slave / table configuration
  logic [43:0] tab[NE];
  logic [15:0] scr[$];
  logic [15:0] rd_q[$];
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit          b_never = 0, r_never = 0;
  logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [43:0] ent(input logic [1:0] op, input logic [4:0] phy,
                                      input logic [4:0] rg, input logic [15:0] d,
                                      input logic [15:0] m);
    return {op, phy, rg, d, m};
  endfunction

  // Table-level model: which transactions must appear and how the run must end.
  task automatic run_model();
    logic [1:0] op;
    logic [9:0] a;
    logic [15:0] d, m, v;
    int k, tries;
    bit ok;
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    exp_done = 0; exp_err = 0; exp_idx = 0; exp_code = 0; k = 0;
    for (int i = 0; i < NE; i++) begin
      {op, a, d, m} = tab[i];
      if (op == 2'b11) begin exp_done = 1; return; end
      if (op == 2'b00) begin
        exp_aw_q.push_back(a);
        exp_w_q.push_back(d);
        if (b_never) begin exp_err = 1; exp_idx = 5'(i); exp_code = 2'b11; return; end
        if (bresp_v != 2'b00) begin exp_err = 1; exp_idx = 5'(i); exp_code = 2'b01; return; end
      end else begin
        tries = (op == 2'b10) ? PL : 1;
        ok = 0;
        for (int t = 0; t < tries && !ok; t++) begin
          exp_ar_q.push_back(a);
          if (r_never) begin exp_err = 1; exp_idx = 5'(i); exp_code = 2'b11; return; end
          v = (k < scr.size()) ? scr[k] : 16'h0;
          k++;
          m_last = v;
          if (rresp_v != 2'b00) begin exp_err = 1; exp_idx = 5'(i); exp_code = 2'b01; return; end
          ok = ((v & m) == (d & m));
        end
        if (!ok) begin exp_err = 1; exp_idx = 5'(i); exp_code = 2'b10; return; end
      end
    end
    exp_done = 1;
  endtask

  // AXI-lite slave: ready after a programmable number of valid cycles
  initial begin
    int aw_c, w_c, ar_c;
    bit r_hs_pend;
    aw_c = 0; w_c = 0; ar_c = 0; r_hs_pend = 0;
    forever begin
      @(negedge clk);
      if (r_hs_pend && rd_q.size() > 0) void'(rd_q.pop_front());
      awready = awvalid && (aw_c >= aw_delay);
      aw_c    = awvalid ? aw_c + 1 : 0;
      wready  = wvalid && (w_c >= w_delay);
      w_c     = wvalid ? w_c + 1 : 0;
      bvalid  = bready && !b_never;
      bresp   = bresp_v;
      arready = arvalid && (ar_c >= ar_delay);
      ar_c    = arvalid ? ar_c + 1 : 0;
      rvalid  = rready && !r_never;
      rresp   = rresp_v;
      rdata   = (rd_q.size() > 0) ? rd_q[0] : 16'h0;
      r_hs_pend = rvalid && rready;
    end
  end

  // compare process: every handshake against the expected queues, plus bus hygiene
  initial begin
    bit aw_hold;
    logic [9:0] hold_aw;
    aw_hold = 0; hold_aw = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (reset_n) begin
        if (awvalid && awready) begin
          aw_hs_cnt++;
          if (exp_aw_q.size() == 0) check("aw_unexpected", exp_aw_q.size(), 1);
          else check("awaddr", awaddr, exp_aw_q.pop_front());
        end
        if (wvalid && wready) begin
          if (exp_w_q.size() == 0) check("w_unexpected", exp_w_q.size(), 1);
          else check("wdata", wdata, exp_w_q.pop_front());
        end
        if (arvalid && arready) begin
          ar_times.push_back(cyc);
          if (exp_ar_q.size() == 0) check("ar_unexpected", exp_ar_q.size(), 1);
          else check("araddr", araddr, exp_ar_q.pop_front());
        end
        if (aw_hold && awvalid) check("awaddr_hold", awaddr, hold_aw);
        aw_hold = awvalid && !awready;
        hold_aw = awaddr;
        if (wvalid && !awvalid) stag_cnt++;
        if (!busy) check("idle_quiet", {awvalid, wvalid, bready, arvalid, rready}, 0);
      end else begin
        aw_hold = 0;
      end
    end
  end

  task automatic set_table();
    cfg_table = {tab[2], tab[1], tab[0]};
    rd_q = scr;
  endtask

  task automatic slave_defaults();
    aw_delay = 0; w_delay = 0; ar_delay = 0;
    b_never = 0; r_never = 0; bresp_v = 2'b00; rresp_v = 2'b00;
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run(output int n);
    int g;
    n = 0; g = 0;
    while (!busy && g < 50) begin @(negedge clk); g++; end
    check("busy_rise", busy, 1);
    while (busy && n < 3000) begin n++; @(negedge clk); end
    check("busy_fall", busy, 0);
  endtask

  task automatic post_check();
    check("done", done, exp_done);
    check("error", error, exp_err);
    check("error_index", error_index, exp_idx);
    check("error_code", error_code, exp_code);
    check("last_rdata", last_rdata, m_last);
    check("aw_left", exp_aw_q.size(), 0);
    check("w_left", exp_w_q.size(), 0);
    check("ar_left", exp_ar_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", {busy, done, error, error_index, error_code,
                       awvalid, wvalid, bready, arvalid, rready}, 0);
    check("rst_last_rdata", last_rdata, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_araddr", araddr, 0);
    check("rst_wdata", wdata, 0);
  endtask

  // driver / directed tests
  initial begin
    int n;
    logic [43:0] e_end;
    e_end = ent(2'b11, 5'h0, 5'h0, 16'h0, 16'h0);

    // single write then END, launched by AUTO_START
    tab[0] = ent(2'b00, 5'h0C, 5'h18, 16'h0030, 16'hFFFF); tab[1] = e_end; tab[2] = e_end;
    scr = {}; slave_defaults(); set_table(); run_model();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    wait_run(n);
    check("write_end_cycles", n, 5);
    post_check();
    check("awaddr_lit", awaddr, 10'h198);
    check("wdata_lit", wdata, 16'h0030);

    // three back-to-back writes: 4 cycles each
    tab[0] = ent(2'b00, 5'h01, 5'h01, 16'h1111, 16'hFFFF);
    tab[1] = ent(2'b00, 5'h02, 5'h02, 16'h2222, 16'hFFFF);
    tab[2] = ent(2'b00, 5'h03, 5'h03, 16'h3333, 16'hFFFF);
    scr = {}; set_table(); run_model(); aw_hs_cnt = 0;
    kick(); wait_run(n);
    check("three_write_cycles", n, 12);
    check("three_write_count", aw_hs_cnt, 3);
    post_check();

    // READ_VERIFY pass
    tab[0] = ent(2'b01, 5'h01, 5'h02, 16'h0100, 16'h0100); tab[1] = e_end; tab[2] = e_end;
    scr = {16'h0104}; set_table(); run_model();
    kick(); wait_run(n);
    post_check();
    check("rv_pass_last", last_rdata, 16'h0104);
    check("rv_pass_done", done, 1);

    // READ_VERIFY mismatch
    scr = {16'h0004}; set_table(); run_model();
    kick(); wait_run(n);
    post_check();
    check("rv_fail_code", error_code, 2'b10);
    check("rv_fail_index", error_index, 5'd0);

    // POLL matching on the third read; a start pulse mid-run must be ignored
    tab[0] = ent(2'b10, 5'h03, 5'h01, 16'h0004, 16'h0004);
    scr = {16'h0000, 16'h0000, 16'h0004}; set_table(); run_model(); ar_times.delete();
    kick();
    repeat (5) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_run(n);
    post_check();
    check("poll_reads", ar_times.size(), 3);
    for (int i = 1; i < ar_times.size(); i++)
      check("poll_gap", (ar_times[i] - ar_times[i-1]) >= PI, 1);

    // POLL never matching: POLL_LIMIT reads then mismatch error
    scr = {16'h0000, 16'h0001, 16'h0000, 16'h0003}; set_table(); run_model(); ar_times.delete();
    kick(); wait_run(n);
    post_check();
    check("poll_fail_reads", ar_times.size(), 4);
    check("poll_fail_code", error_code, 2'b10);

    // staggered write handshakes: wready three cycles after awready
    tab[0] = ent(2'b00, 5'h07, 5'h09, 16'hA5A5, 16'hFFFF);
    scr = {}; set_table(); w_delay = 3; run_model(); stag_cnt = 0;
    kick(); wait_run(n);
    post_check();
    check("stagger_wvalid_only", stag_cnt, 3);
    slave_defaults();

    // bad write response on entry 1
    tab[0] = ent(2'b01, 5'h01, 5'h02, 16'h0100, 16'h0100);
    tab[1] = ent(2'b00, 5'h05, 5'h06, 16'h1234, 16'hFFFF);
    scr = {16'h0104}; set_table(); bresp_v = 2'b10; run_model();
    kick(); wait_run(n);
    post_check();
    check("bresp_index", error_index, 5'd1);
    check("bresp_code", error_code, 2'b01);
    slave_defaults();

    // no write response: phase timeout
    tab[0] = ent(2'b00, 5'h0A, 5'h0B, 16'h5555, 16'hFFFF); tab[1] = e_end;
    scr = {}; set_table(); b_never = 1; run_model();
    kick(); wait_run(n);
    post_check();
    check("timeout_code", error_code, 2'b11);
    check("timeout_len", (n >= TO) && (n <= TO + 4), 1);
    slave_defaults();

    // END in the middle stops the list
    tab[0] = ent(2'b00, 5'h11, 5'h12, 16'h0F0F, 16'hFFFF); tab[1] = e_end;
    tab[2] = ent(2'b00, 5'h13, 5'h14, 16'hF0F0, 16'hFFFF);
    scr = {}; set_table(); run_model(); aw_hs_cnt = 0;
    kick(); wait_run(n);
    post_check();
    check("end_write_count", aw_hs_cnt, 1);

    // reset while waiting for read data, then AUTO_START re-run from entry 0
    tab[0] = ent(2'b00, 5'h02, 5'h03, 16'hBEEF, 16'hFFFF);
    tab[1] = ent(2'b01, 5'h04, 5'h05, 16'h0100, 16'h0100); tab[2] = e_end;
    scr = {}; set_table(); r_never = 1; run_model();
    kick();
    n = 0;
    while (!rready && n < 100) begin @(negedge clk); n++; end
    check("reached_rd_resp", rready, 1);
    check("partial_aw_left", exp_aw_q.size(), 0);
    check("partial_ar_left", exp_ar_q.size(), 0);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    m_last = 16'h0;
    repeat (2) @(negedge clk);
    r_never = 0; scr = {16'h0180}; set_table(); run_model(); aw_hs_cnt = 0;
    reset_n = 1'b1;
    wait_run(n);
    post_check();
    check("restart_write_count", aw_hs_cnt, 1);
    check("restart_last", last_rdata, 16'h0180);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_config_sequencer.md
Name: mdio_config_sequencer

Overview:
- Table-driven MDIO configuration engine. After reset (or on `start`), it walks a parameterised list of PHY register operations: write, read-verify and poll-until-match.
- It drives an AXI-lite master port into a multi-PHY mdio_master, which decodes address {phy[4:0], reg[4:0]}.
- It replaces ad-hoc, hardcoded single-register AXI-lite pokes. It reports `done` or `error` with the index of the failing entry.
- It sits between top-level bring-up logic and the MDIO master, on the `udp_sys_clk` domain.

Parameters:
- NUM_ENTRIES, 4: number of table entries (1..32).
- POLL_LIMIT, 16: maximum read attempts for a POLL entry before error.
- POLL_INTERVAL, 1024: idle cycles between POLL reads.
- TIMEOUT_CYCLES, 65535: maximum cycles waiting on any single AXI-lite handshake phase.
- AUTO_START, 1: if 1, begin the sequence on the first cycle after reset deassertion without needing `start`.

Ports:
- clk  in  1  sequencer and AXI-lite clock.
- reset_n  in  1  asynchronous assert, active-low reset.
- start  in  1  single-cycle pulse; starts the sequence from entry 0 when in IDLE, DONE or ERROR.
- cfg_table  in  44*NUM_ENTRIES  entry i occupies [44*i+43 : 44*i], packed as {op[1:0], phy[4:0], reg[4:0], data[15:0], mask[15:0]}; must be held stable while busy.
- busy  out  1  sequence in progress.
- done  out  1  sticky; set when all entries complete without error.
- error  out  1  sticky; set on a failed entry.
- error_index  out  5  index of the failing entry.
- error_code  out  2  failure cause: 01 bad resp, 10 verify/poll mismatch, 11 timeout.
- last_rdata  out  16  most recent rdata accepted.
- awaddr  out  10  {phy, reg}.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- wdata  out  16  write data.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- bresp  in  2  write response code.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.
- araddr  out  10  {phy, reg}.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  16  read data.
- rresp  in  2  read response code.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.

Behaviour:
- Reset values:
  - All valid/ready outputs, busy, done and error are 0.
  - awaddr, araddr, wdata, last_rdata, error_index and error_code are 0.
  - FSM is in IDLE; entry index is 0.
- Ops:
  - 00 WRITE.
  - 01 READ_VERIFY: pass iff (rdata & mask) == (data & mask).
  - 10 POLL: repeat the read until the same compare passes.
  - 11 END: terminates the list early with success.
- FSM states: IDLE, LOAD, WR_REQ, WR_RESP, RD_REQ, RD_RESP, CHECK, POLL_WAIT, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR -> LOAD:
  - Triggered on `start`, or on the first post-reset cycle if AUTO_START=1.
  - Clears done, error, error_code and error_index, sets busy, and sets index to 0.
- LOAD:
  - Registers entry[index] and sets the poll count to 0.
  - WRITE -> WR_REQ; READ_VERIFY or POLL -> RD_REQ; END -> DONE.
- WR_REQ:
  - awvalid and wvalid assert together; each deasserts independently on the cycle after its own valid&ready.
  - Address/data are held stable while valid.
  - When both handshakes are complete -> WR_RESP with bready=1.
- WR_RESP:
  - On bvalid&bready, bready drops.
  - bresp!=0 -> ERROR (code 01); otherwise -> NEXT.
- RD_REQ:
  - arvalid=1 until arready; then -> RD_RESP with rready=1.
- RD_RESP:
  - On rvalid&rready, capture last_rdata and drop rready.
  - rresp!=0 -> ERROR (code 01); otherwise -> CHECK.
- CHECK:
  - Match -> NEXT.
  - Mismatch on READ_VERIFY -> ERROR (code 10).
  - Mismatch on POLL: increment the poll count; if it equals POLL_LIMIT -> ERROR (code 10), else -> POLL_WAIT.
- POLL_WAIT:
  - Counts POLL_INTERVAL cycles, then -> RD_REQ.
- NEXT:
  - If index == NUM_ENTRIES-1 -> DONE; otherwise increment index -> LOAD.
- Timeout:
  - A per-phase counter resets on each state entry.
  - Reaching TIMEOUT_CYCLES in WR_REQ, WR_RESP, RD_REQ or RD_RESP -> ERROR (code 11).
  - On timeout, all valid/ready outputs deassert the same cycle.
- DONE: busy=0, done=1. ERROR: busy=0, error=1, error_index = index.
- `start` while busy is ignored.
- Simultaneous awready and wready on the first valid cycle completes WR_REQ in 1 cycle.
- The minimum WRITE entry takes LOAD + 1 (WR_REQ) + 1 (WR_RESP) + NEXT = 4 cycles with an always-ready slave.
- reset_n low mid-transaction:
  - Immediately returns all outputs to their reset values.
  - No handshake is completed.
  - With AUTO_START=1, the sequence restarts after release.

Test Plan:
- Single WRITE {00, 0x0C, 0x18, 0x0030, 0xFFFF}, NUM_ENTRIES=1, always-ready slave, bresp=0:
  - awaddr=0x198 and wdata=0x0030 on the same cycle.
  - done=1 after 4 cycles.
  - No second write is issued.
- READ_VERIFY entry with data 0x0100, mask 0x0100, slave rdata 0x0104 -> pass, with last_rdata=0x0104.
- Same READ_VERIFY entry with rdata 0x0004 -> error=1, error_code=10, error_index=0.
- POLL entry with mask 0x0004 and data 0x0004, POLL_LIMIT=4:
  - Slave returns 0x0000, 0x0000, then 0x0004 -> exactly 3 reads, each separated by ≥POLL_INTERVAL cycles, then done.
  - Slave never matches -> 4 reads, then error_code=10.
- Staggered handshakes:
  - awready 3 cycles before wready -> awvalid drops after its own handshake while wvalid stays held.
  - Slave never asserts bvalid -> error_code=11 after TIMEOUT_CYCLES.
- END early exit and mid-sequence reset:
  - Table of 3 entries with entry 1 = END -> only entry 0 is executed, then done.
  - reset_n pulsed low during RD_RESP -> all outputs 0 asynchronously; AUTO_START restarts from entry 0.
